// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// The responder side of the CPU data-memory interface. It accepts one load or
// store request from the EX/MEM stage, holds BUSYWAIT high for a fixed number
// of cycles while the access runs, then spends one DONE cycle with BUSYWAIT low
// so the pipeline can advance. It supports RV32 byte, halfword and word stores
// and sign- or zero-extended loads on an internal word array.
//
// Parameters
//   DEPTH_WORDS    number of 32-bit words (power of two, at least 2)
//   LATENCY        number of BUSY cycles per access (at least 1)
//
// Ports
//   CLK            clock; all state changes on the rising edge
//   RESET          synchronous, active-high reset; overrides everything
//   MEM_READ       load request (held stable by the CPU while BUSYWAIT=1)
//   MEM_WRITE      store request (held stable by the CPU while BUSYWAIT=1)
//   FUNC3          RV32 funct3 of the load/store
//   MEM_ADDRESS    byte address
//   MEM_WRITE_DATA store data (SB and SH use only the low byte or halfword)
//   READ_DATA      registered load result; changes only when a load commits
//   BUSYWAIT       stall request to the pipeline
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            busy_int;

  // Request captured at accept time. The CPU holds its inputs stable while the
  // access runs, but latching makes the commit independent of that promise.
  logic            op_write_reg;
  logic            op_read_reg;
  logic [AW-1:0]   idx_reg;
  logic [1:0]      lane_reg;
  logic [31:0]     wdata_reg;
  logic [2:0]      func3_reg;

  logic            request;
  logic            accept;
  logic            commit;

  logic [3:0]      wr_mask;
  logic [31:0]     wr_word;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     load_value;

  // Address bits above the word index are deliberately ignored so accesses
  // wrap modulo the array size.
  wire unused_addr_hi = &{1'b0, MEM_ADDRESS[31:AW+2]};

  assign request = MEM_READ | MEM_WRITE;
  assign accept  = (state_reg == ST_IDLE) && request && !RESET;
  assign commit  = (state_reg == ST_BUSY) && (cnt_reg == '0) && !RESET;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy_int   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Stall immediately in the cycle the request shows up, so the
        // pipeline never advances past an unserviced access.
        if (request) begin
          busy_int   = 1'b1;
          state_next = ST_BUSY;
          cnt_next   = CW'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        busy_int = 1'b1;
        if (cnt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_DONE: begin
        // The request inputs still show the finished access here; they are
        // ignored so the same access is not serviced twice.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign BUSYWAIT = busy_int & ~RESET;

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_write_reg <= 1'b0;
      op_read_reg  <= 1'b0;
      idx_reg      <= '0;
      lane_reg     <= '0;
      wdata_reg    <= '0;
      func3_reg    <= '0;
    end else if (accept) begin
      // A simultaneous read and write is treated as a store only.
      op_write_reg <= MEM_WRITE;
      op_read_reg  <= MEM_READ & ~MEM_WRITE;
      idx_reg      <= MEM_ADDRESS[AW+1:2];
      lane_reg     <= MEM_ADDRESS[1:0];
      wdata_reg    <= MEM_WRITE_DATA;
      func3_reg    <= FUNC3;
    end
  end

  // ---------------------------------------------------------------------------
  // Store lane steering. Replicating the byte/halfword across the word lets
  // the byte-enable mask alone pick the destination lane.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_mask = 4'b1111;
    wr_word = wdata_reg;
    case (func3_reg[1:0])
      2'b00: begin
        wr_mask = 4'b0001 << lane_reg;
        wr_word = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        wr_mask = lane_reg[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_reg[15:0]}};
      end
      default: begin
        wr_mask = 4'b1111;
        wr_word = wdata_reg;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide array per lane so each lane has a single writer.
  // The array must clear on reset, so every word is reset explicitly.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int i = 0; i < DEPTH_WORDS; i++) begin
            lane_mem[i] <= '0;
          end
        end else if (commit && op_write_reg && wr_mask[gi]) begin
          lane_mem[idx_reg] <= wr_word[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[idx_reg];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load extraction and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane_reg)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    // addr[0] is ignored for halfwords: misaligned accesses align down.
    rd_half = lane_reg[1] ? rd_word[31:16] : rd_word[15:0];

    load_value = rd_word;
    case (func3_reg)
      3'b000:  load_value = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_value = {24'd0, rd_byte};
      3'b001:  load_value = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_value = {16'd0, rd_half};
      default: load_value = rd_word;
    endcase
  end

  // READ_DATA moves only on a committing load; stores leave it untouched.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      READ_DATA <= '0;
    end else if (commit && op_read_reg) begin
      READ_DATA <= load_value;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;

  int checks = 0;
  int errors = 0;

  bit [31:0] model_mem [DEPTH];
  bit [31:0] model_rd;

  data_memory #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .MEM_READ       (MEM_READ),
    .MEM_WRITE      (MEM_WRITE),
    .FUNC3          (FUNC3),
    .MEM_ADDRESS    (MEM_ADDRESS),
    .MEM_WRITE_DATA (MEM_WRITE_DATA),
    .READ_DATA      (READ_DATA),
    .BUSYWAIT       (BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: words as plain integers, lanes picked by arithmetic.
  function automatic bit [31:0] model_store(bit [31:0] w, bit [2:0] f3, bit [31:0] addr, bit [31:0] d);
    int unsigned sh;
    case (f3 % 4)
      0: begin
        sh = 8 * (addr % 4);
        return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end
      1: begin
        sh = 16 * ((addr / 2) % 2);
        return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end
      default: return d;
    endcase
  endfunction

  function automatic bit [31:0] model_load(bit [31:0] w, bit [2:0] f3, bit [31:0] addr);
    bit [31:0] byte_v;
    bit [31:0] half_v;
    byte_v = (w >> (8 * (addr % 4))) & 32'hFF;
    half_v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (byte_v >= 128) ? byte_v + 32'hFFFF_FF00 : byte_v;
      3'd4:    return byte_v;
      3'd1:    return (half_v >= 32768) ? half_v + 32'hFFFF_0000 : half_v;
      3'd5:    return half_v;
      default: return w;
    endcase
  endfunction

  // Called just after a rising edge with the DUT idle; returns just after the
  // edge that follows the DONE cycle, so a following call is back-to-back.
  task automatic access(input bit rd, input bit wr, input bit [2:0] f3,
                        input bit [31:0] addr, input bit [31:0] data, input string name);
    bit [31:0]   prev_rd;
    int unsigned idx;
    prev_rd = model_rd;
    idx     = (addr / 4) % DEPTH;
    if (wr) model_mem[idx] = model_store(model_mem[idx], f3, addr, data);
    else if (rd) model_rd = model_load(model_mem[idx], f3, addr);

    MEM_READ       = rd;
    MEM_WRITE      = wr;
    FUNC3          = f3;
    MEM_ADDRESS    = addr;
    MEM_WRITE_DATA = data;
    #1;
    check({name, ".busy_c0"}, {31'd0, BUSYWAIT}, 32'd1);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge CLK); #1;
      check({name, ".busy"}, {31'd0, BUSYWAIT}, 32'd1);
      check({name, ".rd_hold"}, READ_DATA, prev_rd);
    end
    @(posedge CLK); #1;
    check({name, ".busy_done"}, {31'd0, BUSYWAIT}, 32'd0);
    check({name, ".rdata"}, READ_DATA, model_rd);
    $display("%s rd=%0d wr=%0d f3=%0d addr=%08h wdata=%08h rdata=%08h",
             name, rd, wr, f3, addr, data, READ_DATA);
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1;
      check("idle.busy", {31'd0, BUSYWAIT}, 32'd0);
      check("idle.rdata", READ_DATA, model_rd);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    bit [31:0] addr;
    int        kind;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rd       = '0;
    RESET          = 1'b1;
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    FUNC3          = 3'd0;
    MEM_ADDRESS    = '0;
    MEM_WRITE_DATA = '0;

    // Reset for two cycles; a request during reset must not raise BUSYWAIT.
    @(posedge CLK); #1;
    MEM_READ = 1'b1;
    #1;
    check("reset.busy", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK); #1;
    RESET    = 1'b0;
    MEM_READ = 1'b0;
    check("reset.rdata", READ_DATA, 32'd0);
    idle(5);

    // Directed sequence from the test plan.
    access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, "SW");
    access(1, 0, 3'd2, 32'h10, 32'h0, "LW");
    access(0, 1, 3'd0, 32'h12, 32'hAAAAAA7F, "SB");
    access(1, 0, 3'd2, 32'h10, 32'h0, "LW");
    access(1, 0, 3'd0, 32'h13, 32'h0, "LB");
    access(1, 0, 3'd4, 32'h13, 32'h0, "LBU");
    access(1, 0, 3'd1, 32'h10, 32'h0, "LH");
    access(1, 0, 3'd5, 32'h12, 32'h0, "LHU");
    access(0, 1, 3'd2, 32'(4 * DEPTH), 32'h11111111, "SW_WRAP");
    access(1, 0, 3'd2, 32'h0, 32'h0, "LW_WRAP");
    access(1, 0, 3'd2, 32'h13, 32'h0, "LW_MISAL");
    access(1, 1, 3'd2, 32'h20, 32'hA5A5A5A5, "RW_BOTH");
    access(1, 0, 3'd2, 32'h20, 32'h0, "LW");
    idle(3);

    // Randomized accesses on a small window so reads hit earlier writes.
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 2));
      addr = ($urandom & ~32'(4 * DEPTH - 1)) | 32'($urandom_range(0, 63));
      access(kind != 1, kind != 0, 3'($urandom_range(0, 7)), addr, $urandom, "RND");
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    // Reset in the second BUSY cycle aborts the store and clears the array.
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b1;
    FUNC3          = 3'd2;
    MEM_ADDRESS    = 32'h30;
    MEM_WRITE_DATA = 32'h12345678;
    #1;
    check("rstmid.busy_c0", {31'd0, BUSYWAIT}, 32'd1);
    @(posedge CLK); #1;
    check("rstmid.busy_b1", {31'd0, BUSYWAIT}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    check("rstmid.busy_rst", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK); #1;
    RESET     = 1'b0;
    MEM_WRITE = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rd = '0;
    check("rstmid.rdata", READ_DATA, 32'd0);
    idle(2);
    access(1, 0, 3'd2, 32'h30, 32'h0, "LW_AFTER_RST");
    access(1, 0, 3'd2, 32'h20, 32'h0, "LW_CLEARED");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Responder end of the CPU data-memory interface. It accepts the load/store requests driven by the pipeline's EX/MEM stage (MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, FUNC3) and holds BUSYWAIT high while the access is in progress, which freezes all pipeline registers. Accesses take a fixed multi-cycle latency. The block performs RV32 byte, halfword and word stores, and sign- or zero-extended loads, on an internal word array.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two.
- LATENCY, 3: number of BUSY-state cycles per access; must be ≥1.

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- MEM_READ  in  1  load request; held stable by the CPU while BUSYWAIT=1.
- MEM_WRITE  in  1  store request; held stable by the CPU while BUSYWAIT=1.
- FUNC3  in  3  RV32 funct3 of the load/store.
- MEM_ADDRESS  in  32  byte address.
- MEM_WRITE_DATA  in  32  store data; the low byte or low halfword is used for SB and SH.
- READ_DATA  out  32  registered load result.
- BUSYWAIT  out  1  stall request to the pipeline.

## Operation
**States:** IDLE, BUSY, DONE.

**IDLE**
- A request is MEM_READ | MEM_WRITE.
- With a request present, BUSYWAIT=1 combinationally in the same cycle.
- At the clock edge the block latches the operation, address, write data and FUNC3, loads cnt=LATENCY-1, and moves to BUSY.
- With no request, BUSYWAIT=0 and the block stays in IDLE.

**BUSY**
- BUSYWAIT=1.
- If cnt≠0, decrement cnt.
- If cnt=0, commit the access at this edge and move to DONE.

**DONE**
- BUSYWAIT=0. The pipeline advances in this cycle.
- Request inputs are ignored in this cycle, even though they still show the old request.
- Move unconditionally to IDLE.

**Addressing**
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses wrap modulo the array size.
- Byte lane = addr[1:0].
- Halfword select = addr[1]; addr[0] is ignored.
- Word accesses ignore addr[1:0].
- Misaligned accesses are therefore aligned down. No exception is raised.

**Stores (FUNC3[1:0])**
- 00 SB: write the byte lane only.
- 01 SH: write the selected halfword only.
- 10 SW: write the full word.
- 11: treated as SW.
- FUNC3[2] is ignored.

**Loads**
- 000 LB: sign-extend the selected byte.
- 100 LBU: zero-extend the selected byte.
- 001 LH: sign-extend the selected halfword.
- 101 LHU: zero-extend the selected halfword.
- 010 LW, and all other codes: full word.

**Output and priority rules**
- READ_DATA updates only when a load commits. Stores and idle cycles leave READ_DATA unchanged.
- If MEM_READ and MEM_WRITE are both 1, the request is a store. READ_DATA is unchanged.

## Timing
- Request first seen in cycle 0 → BUSYWAIT high in cycles 0..LATENCY (LATENCY+1 cycles).
- DONE occurs in cycle LATENCY+1, with BUSYWAIT=0 and READ_DATA valid.
- A back-to-back request that appears in the cycle after DONE is accepted normally. Minimum spacing between accepts is LATENCY+2 cycles.
- Read-after-write to the same word returns the newly stored data. The store commits before a later request can be accepted.

**Reset**
- Synchronous, active-high, and overrides every other action.
- On reset: state=IDLE, cnt=0, READ_DATA=0, all array words cleared to 0.
- BUSYWAIT is forced to 0 in any cycle where RESET=1.
- Reset during BUSY aborts the access: no array write and no READ_DATA update.

## Test plan
- **Reset, then idle.** Assert RESET for 2 cycles and keep requests low for 5 cycles → READ_DATA=0, BUSYWAIT=0 throughout, state IDLE.
- **SW then LW (LATENCY=3).** SW 0xDEADBEEF to address 0x10, then LW from 0x10 → each access shows BUSYWAIT=1 for exactly 4 cycles and then 0 for 1 cycle. READ_DATA=0xDEADBEEF in the LW DONE cycle.
- **Sub-word accesses.** After word 0x10 = 0xDEADBEEF:
  - SB 0x7F to address 0x12, then LW 0x10 → 0xDE7FBEEF.
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x10 → 0xFFFFBEEF.
  - LHU 0x12 → 0x0000DE7F.
- **Back-to-back and wrap.**
  - SW 0x11111111 to address 4×DEPTH_WORDS immediately followed by LW 0x0 → the second request is accepted in the cycle after DONE, and READ_DATA=0x11111111.
  - LW with address 0x13 (misaligned) returns word 0x10.
- **Simultaneous read and write.** Assert MEM_READ=MEM_WRITE=1 with SW data 0xA5A5A5A5 to 0x20 → the store is performed and READ_DATA holds its previous value. A following LW 0x20 returns 0xA5A5A5A5.
- **Reset mid-access.** Issue SW 0x12345678 to 0x30 and assert RESET in the 2nd BUSY cycle → BUSYWAIT drops in the reset cycle, and a later LW 0x30 returns 0x00000000.
